// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  // ADDI x0, x0, 0 opcode field, loaded into bubbled stages
  localparam logic [6:0] NOP_OPCODE = 7'b0010011;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register enable/flush sequencer: load-use, mispredict, memory wait and halt drain.
//   state    | meaning
//   RUN      | normal issue, per-cycle hazard resolution
//   MEM_WAIT | data memory pending, upstream registers frozen
//   DRAIN    | halt seen, older instructions retiring
//   HALTED   | pipeline empty and stopped
//   ERR      | memory timeout, stopped
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_halt,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_br_valid,
  input  logic                 ex_taken,
  input  logic                 ex_bpr,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 idex_we,
  output logic                 exmem_we,
  output logic                 memwb_we,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 memwb_flush,
  output logic                 redirect,
  output logic                 HALT,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state;
  logic               run_ok;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic mem_stall, mispredict, load_use, wait_expired;
  logic stall_inc, flush_inc;

  assign mem_stall    = mem_req & ~mem_ack;
  assign mispredict   = ex_br_valid & (ex_taken != ex_bpr);
  assign load_use     = ex_is_load & (ex_rd != '0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign wait_expired = (wait_cnt + 1'b1) == WAIT_W'(MEM_TIMEOUT);

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    HALT        = 1'b0;
    mem_err     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    // Hold everything as bubbles until the first clock edge after reset release
    if (!run_ok) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
      {ifid_flush, idex_flush, memwb_flush}         = '1;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            {pc_we, ifid_we, idex_we, exmem_we} = '0;
            memwb_flush = 1'b1;
          end else if (mispredict) begin
            redirect   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_halt) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ack) begin
            {pc_we, ifid_we, idex_we, exmem_we} = '0;
            memwb_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (mem_stall) begin
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
          end
        end
        HALTED: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          HALT = 1'b1;
        end
        default: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          HALT    = 1'b1;
          mem_err = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= RUN;
      run_ok    <= 1'b0;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else if (!run_ok) begin
      run_ok <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (!mispredict && !load_use && id_halt) begin
            state     <= DRAIN;
            // The halt cycle itself retires the WB instruction, so it counts as one drain cycle
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (mem_stall) begin
            if (wait_expired) state <= ERR;
            else              wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
            if (drain_cnt <= DRAIN_W'(1)) begin
              state     <= HALTED;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (stall_inc),
    .clear (1'b0),
    .value (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (flush_inc),
    .clear (1'b0),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and 2-bit counters.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT  = 4;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 2;

  // {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,memwb}_flush, redirect, HALT, mem_err
  localparam logic [10:0] RST_V    = 11'b00000_111_000;
  localparam logic [10:0] RUN_V    = 11'b11111_000_000;
  localparam logic [10:0] LU_V     = 11'b00111_010_000;
  localparam logic [10:0] MP_V     = 11'b11111_110_100;
  localparam logic [10:0] MW_V     = 11'b00001_001_000;
  localparam logic [10:0] DRF_V    = 11'b00001_011_000;
  localparam logic [10:0] HALTED_V = 11'b00000_000_010;
  localparam logic [10:0] ERR_V    = 11'b00000_000_011;

  logic CLK = 1'b0;
  logic RSTn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, id_halt, ex_is_load, ex_br_valid, ex_taken, ex_bpr;
  logic mem_req, mem_ack;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, memwb_flush, redirect, HALT, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [10:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, memwb_flush, redirect, HALT, mem_err};

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_halt    (id_halt),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_br_valid(ex_br_valid),
    .ex_taken   (ex_taken),
    .ex_bpr     (ex_bpr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .idex_we    (idex_we),
    .exmem_we   (exmem_we),
    .memwb_we   (memwb_we),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .memwb_flush(memwb_flush),
    .redirect   (redirect),
    .HALT       (HALT),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_halt = 1'b0;
    ex_is_load = 1'b0; ex_br_valid = 1'b0; ex_taken = 1'b0; ex_bpr = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    idle_inputs();
    tick();
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle_inputs();
    #2;
    n_cmp++;
    if (ctl !== RST_V) begin n_err++; $display("FAIL reset_hold: got %b expected %b", ctl, RST_V); end
    tick();
    RSTn = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== RST_V) begin n_err++; $display("FAIL release_before_edge: got %b expected %b", ctl, RST_V); end
    tick();
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL first_run: got %b expected %b", ctl, RUN_V); end
    n_cmp++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== LU_V) begin n_err++; $display("FAIL lu_rs2: got %b expected %b", ctl, LU_V); end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL lu_after: got %b expected %b", ctl, RUN_V); end
    n_cmp++;
    if (stall_cnt !== 2'd1) begin n_err++; $display("FAIL lu_cnt1: got %0d expected 1", stall_cnt); end
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL lu_x0: got %b expected %b", ctl, RUN_V); end
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL lu_unused_src: got %b expected %b", ctl, RUN_V); end
    tick();
    id_use_rs1 = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== LU_V) begin n_err++; $display("FAIL lu_rs1: got %b expected %b", ctl, LU_V); end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (stall_cnt !== 2'd2) begin n_err++; $display("FAIL lu_cnt2: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_mispredict();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    ex_br_valid = 1'b1; ex_taken = 1'b1; ex_bpr = 1'b0;
    #2;
    n_cmp++;
    if (ctl !== MP_V) begin n_err++; $display("FAIL mp_over_lu: got %b expected %b", ctl, MP_V); end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (stall_cnt !== 2'd2 || flush_cnt !== 2'd1) begin
      n_err++; $display("FAIL mp_counts: got %0d/%0d expected 2/1", stall_cnt, flush_cnt);
    end
    ex_br_valid = 1'b1; ex_taken = 1'b1; ex_bpr = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL br_correct: got %b expected %b", ctl, RUN_V); end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (flush_cnt !== 2'd1) begin n_err++; $display("FAIL br_correct_cnt: got %0d expected 1", flush_cnt); end
  endtask

  task automatic test_back_to_back();
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (ctl !== LU_V) begin n_err++; $display("FAIL b2b_lu%0d: got %b expected %b", i, ctl, LU_V); end
      tick();
    end
    idle_inputs();
    #2;
    n_cmp++;
    if (stall_cnt !== 2'd3) begin n_err++; $display("FAIL stall_saturate: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; mem_ack = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL mem_same_cycle_ack: got %b expected %b", ctl, RUN_V); end
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin ex_br_valid = 1'b1; ex_taken = 1'b0; ex_bpr = 1'b1; end
      #2;
      n_cmp++;
      if (ctl !== MW_V) begin n_err++; $display("FAIL mem_wait%0d: got %b expected %b", i, ctl, MW_V); end
      tick();
    end
    ex_br_valid = 1'b0;
    mem_ack = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL mem_ack: got %b expected %b", ctl, RUN_V); end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (ctl !== RUN_V || flush_cnt !== 2'd1) begin
      n_err++; $display("FAIL mem_after: got %b/%0d expected %b/1", ctl, flush_cnt, RUN_V);
    end
  endtask

  task automatic test_halt_drain();
    int rise;
    id_halt = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== LU_V) begin n_err++; $display("FAIL halt_detect: got %b expected %b", ctl, LU_V); end
    tick();
    id_halt = 1'b0;
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      #2;
      n_cmp++;
      if (ctl !== DRF_V) begin n_err++; $display("FAIL drain_frozen%0d: got %b expected %b", i, ctl, DRF_V); end
      tick();
    end
    mem_req = 1'b0;
    rise = -1;
    for (int k = 3; k <= 12; k++) begin
      #2;
      if (HALT === 1'b1) begin rise = k; break; end
      tick();
    end
    n_cmp++;
    if (rise != DRAIN_CYCLES + 2) begin
      n_err++; $display("FAIL halt_latency: got %0d expected %0d", rise, DRAIN_CYCLES + 2);
    end
    n_cmp++;
    if (ctl !== HALTED_V) begin n_err++; $display("FAIL halted: got %b expected %b", ctl, HALTED_V); end
    ex_br_valid = 1'b1; ex_taken = 1'b1; mem_req = 1'b1;
    tick();
    tick();
    #2;
    n_cmp++;
    if (ctl !== HALTED_V) begin n_err++; $display("FAIL halted_sticky: got %b expected %b", ctl, HALTED_V); end
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== RST_V || stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      n_err++; $display("FAIL reset_from_halted: got %b %0d/%0d expected %b 0/0", ctl, stall_cnt, flush_cnt, RST_V);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #2;
      n_cmp++;
      if (ctl !== MW_V) begin n_err++; $display("FAIL timeout_wait%0d: got %b expected %b", i, ctl, MW_V); end
      tick();
    end
    #2;
    n_cmp++;
    if (ctl !== ERR_V) begin n_err++; $display("FAIL timeout_err: got %b expected %b", ctl, ERR_V); end
    mem_ack = 1'b1;
    tick();
    tick();
    #2;
    n_cmp++;
    if (ctl !== ERR_V) begin n_err++; $display("FAIL err_sticky: got %b expected %b", ctl, ERR_V); end
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== RST_V) begin n_err++; $display("FAIL reset_from_err: got %b expected %b", ctl, RST_V); end
    do_reset();
    #2;
    n_cmp++;
    if (ctl !== RUN_V) begin n_err++; $display("FAIL run_after_err: got %b expected %b", ctl, RUN_V); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_back_to_back();
    test_mem_wait();
    test_halt_drain();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Every cycle it decides per-register write-enable and flush (bubble insert) from three sources: load-use hazards, branch mispredicts resolved in EX, and data-memory wait handshakes.
- Also drains the pipeline on a halt instruction and asserts HALT once the pipeline is empty.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- MEM_TIMEOUT, 64, max cycles to wait for mem_ack before raising mem_err.
- DRAIN_CYCLES, 3, cycles after halt detect for older instructions (EX, MEM, WB) to retire.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1/rs2.
- id_halt  input  1  instruction in ID is a halt.
- ex_rd  input  5  destination of the instruction in EX.
- ex_is_load  input  1  EX instruction is a load.
- ex_br_valid  input  1  EX holds a resolved B-type or jump.
- ex_taken  input  1  actual branch outcome.
- ex_bpr  input  1  predicted outcome carried down the pipe.
- mem_req  input  1  MEM stage is accessing data memory.
- mem_ack  input  1  data memory completes the access this cycle.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  register enables.
- ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (flush_i=1, opcode NOP) instead of the inputs.
- redirect  output  1  PC takes the corrected target this cycle.
- HALT  output  1  pipeline drained and stopped.
- mem_err  output  1  sticky, memory timeout.
- stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Behaviour:
- Reset (async, RSTn=0):
  - State=RUN, all *_we=0, all *_flush=1, redirect=0, HALT=0, mem_err=0, counters=0, wait/drain counters=0.
  - Enables are only allowed to rise on the first CLK edge after RSTn deasserts.
- States: RUN, MEM_WAIT, DRAIN, HALTED, ERR.
- Outputs are combinational from state plus inputs. State and counters are registered.
- Priority within a cycle: mem wait > mispredict > load-use > halt detect.
- RUN, default: all we=1, all flush=0, redirect=0.
- Mem wait: if mem_req=1 and mem_ack=0:
  - pc/ifid/idex/exmem_we=0, memwb_we=1, memwb_flush=1.
  - Go to MEM_WAIT and load wait_cnt=1.
  - mem_req=1 with mem_ack=1 in the same cycle is not a stall.
- MEM_WAIT:
  - Outputs are as in the mem-wait stall; wait_cnt increments each cycle.
  - mem_ack=1: outputs are RUN defaults that cycle, go to RUN.
  - wait_cnt==MEM_TIMEOUT with no ack: go to ERR and set mem_err.
  - Mispredict and load-use are ignored while waiting; they are re-evaluated after the upstream registers unfreeze.
- Mispredict: ex_br_valid=1 and ex_taken!=ex_bpr:
  - redirect=1, ifid_flush=1, idex_flush=1 for exactly that cycle.
  - flush_cnt+1.
  - A concurrent load-use stall is cancelled, because the ID instruction is squashed.
- Load-use: ex_is_load=1, ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd):
  - pc_we=0, ifid_we=0, idex_flush=1, one cycle.
  - stall_cnt+1.
  - x0 never stalls.
- Halt: id_halt=1 in RUN with no higher-priority event:
  - idex_flush=1 so the halt itself is not issued.
  - pc_we=0, ifid_we=0.
  - Go to DRAIN and load drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - pc_we=0, ifid_we=0, idex_flush=1; the EX/MEM/WB enables stay 1.
  - A mem wait during drain freezes drain_cnt (exmem_we=0, memwb_flush=1).
  - drain_cnt decrements only when not frozen; at 0 go to HALTED.
  - A mispredict during DRAIN is impossible (ID/EX already bubbles) and is ignored.
- HALTED: all we=0, HALT=1. Only reset exits.
- ERR: all we=0, mem_err=1, HALT=1. Only reset exits.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-drain: immediate return to reset values, with no partial counter updates.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERR=4);
  - the NOP opcode constant;
  - the register-index width 5.
- One natural sub-module, sat_counter (CNT_W param; inc, clear, value), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset then release, no hazards:
  - During RSTn=0: all we=0, flush=1.
  - First cycle after release: all we=1, flush=0.
  - stall_cnt=0, flush_cnt=0.
- Load-use, ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1:
  - One cycle of pc_we=0, ifid_we=0, idex_flush=1, then stall_cnt=1.
  - Repeat with ex_rd=0: no stall.
- Mispredict, ex_br_valid=1, ex_taken=1, ex_bpr=0, concurrent with load-use:
  - redirect=1, ifid_flush=idex_flush=1.
  - pc_we=1 and no stall, so stall_cnt is unchanged.
  - flush_cnt=1.
- Mem wait, mem_req=1 held with mem_ack=0 for 3 cycles, then ack:
  - 3 cycles of pc/ifid/idex/exmem_we=0 with memwb_flush=1.
  - RUN defaults on the ack cycle.
- Timeout, MEM_TIMEOUT=4, no ack: after 4 wait cycles mem_err=1, HALT=1, all we=0, until RSTn=0.
- Halt with a mem wait of 2 cycles during drain: HALT rises exactly DRAIN_CYCLES+2 cycles after the id_halt cycle.
